lfsr: RTL and testbench

LFSR -- requirements
Module: lfsr

---
 rtl/lfsr.sv | 43 ++++
 tb/tb_lfsr.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/lfsr.sv
// 6-bit Fibonacci LFSR (x^6 + x^5 + 1), maximal period 63, output taken straight from the state register.
// Optional build macro LFSR_LOCKUP_GUARD_EN: an all-zero state steps to 6'h01 instead of locking up.
module lfsr #(
  parameter logic [5:0] SEED = 6'h01
) (
  input  logic       clock,
  input  logic       reset,
  output logic [5:0] rnd_out
);

  logic [5:0] state_q;
  logic [5:0] state_d;

  function automatic logic [5:0] lfsr_step(input logic [5:0] s);
    return {s[4:0], s[5] ^ s[4]};
  endfunction

  // Next-state selection, including the optional escape from the all-zero lockup state
  always_comb begin
    state_d = lfsr_step(state_q);
`ifdef LFSR_LOCKUP_GUARD_EN
    if (state_q == 6'h00) begin
      state_d = 6'h01;
    end else begin
      state_d = lfsr_step(state_q);
    end
`else
    state_d = lfsr_step(state_q);
`endif
  end

  // State register, forced to SEED asynchronously while reset is high
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign rnd_out = state_q;

endmodule

// File: tb/tb_lfsr.sv
// Self-checking bench for lfsr: three seeds share one clock/reset; an integer-arithmetic model is compared every negedge.
module tb_lfsr;

  logic       clock;
  logic       reset;
  logic [5:0] rnd_a;
  logic [5:0] rnd_b;
  logic [5:0] rnd_c;

  int n_cmp;
  int n_bad;
  bit chk_en;
  int m_a;
  int m_b;
  int m_c;

  lfsr #(.SEED(6'h01)) u_a (.clock(clock), .reset(reset), .rnd_out(rnd_a));
  lfsr #(.SEED(6'h2D)) u_b (.clock(clock), .reset(reset), .rnd_out(rnd_b));
  lfsr #(.SEED(6'h00)) u_c (.clock(clock), .reset(reset), .rnd_out(rnd_c));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Spec rule: shift left by one, new LSB = old bit5 XOR old bit4
  function automatic int model_next(input int s);
`ifdef LFSR_LOCKUP_GUARD_EN
    if (s == 0) return 1;
`endif
    return ((s * 2) % 64) + (((s / 32) % 2) ^ ((s / 16) % 2));
  endfunction

  task automatic check(input string name, input logic [5:0] act, input int exp);
    logic [5:0] e;
    e = exp[5:0];
    n_cmp++;
    if (act !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, e, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic load_models();
    m_a = 1;
    m_b = 45;
    m_c = 0;
  endtask

  // Leaves the bench at posedge+1 with the model advanced if reset is low
  task automatic tick();
    @(posedge clock);
    #1;
    if (!reset) begin
      m_a = model_next(m_a);
      m_b = model_next(m_b);
      m_c = model_next(m_c);
    end
  endtask

  // Called at posedge+1: assert reset mid-cycle, check it acts at once, hold over one edge, release mid-cycle
  task automatic do_reset(input int hold);
    #1;
    reset = 1'b1;
    load_models();
    #1;
    check("async_reset_a", rnd_a, 1);
    check("async_reset_b", rnd_b, 45);
    for (int i = 0; i < hold; i++) tick();
    #1;
    reset = 1'b0;
  endtask

  // Cycle-by-cycle comparison of all instances against the model
  always @(negedge clock) begin
    if (chk_en) begin
      check("model_a", rnd_a, m_a);
      check("model_b", rnd_b, m_b);
      check("model_c", rnd_c, m_c);
    end
  end

  initial begin
    int exp_a [8];
    bit seen [64];
    int distinct;
    int zeros;
    int accepted;
    int runlen;
    exp_a = '{2, 4, 8, 16, 33, 3, 6, 12};
    n_cmp = 0;
    n_bad = 0;
    chk_en = 1'b0;
    reset = 1'b1;
    load_models();
    #1;
    chk_en = 1'b1;

    // Values visible while in reset, then the known start of each sequence
    check("inreset_a", rnd_a, 8'h01);
    check("inreset_b", rnd_b, 8'h2D);
    check("inreset_c", rnd_c, 8'h00);
    tick();
    check("held_a", rnd_a, 8'h01);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("seq_seed01", rnd_a, exp_a[i]);
      if (i == 0) check("seq_seed2d", rnd_b, 8'h1B);
`ifdef LFSR_LOCKUP_GUARD_EN
      if (i == 0) check("seed0_guard1", rnd_c, 8'h01);
      if (i == 1) check("seed0_guard2", rnd_c, 8'h02);
`else
      if (i < 2) check("seed0_stuck", rnd_c, 8'h00);
`endif
    end

    // Full period: each of 1..63 exactly once, back to 01 on clock 63
    do_reset(1);
    for (int v = 0; v < 64; v++) seen[v] = 1'b0;
    distinct = 0;
    zeros = 0;
    for (int i = 0; i < 63; i++) begin
      tick();
      if (rnd_a == 6'h00) zeros++;
      else if (!seen[rnd_a]) begin
        seen[rnd_a] = 1'b1;
        distinct++;
      end
    end
    check_int("period_distinct", distinct, 63, 63);
    check_int("period_zeros", zeros, 0, 0);
    check("period_wrap", rnd_a, 8'h01);

    // Mid-sequence async reset after 20 clocks, then the sequence restarts
    do_reset(0);
    for (int i = 0; i < 20; i++) tick();
    do_reset(0);
    tick();
    check("restart_1", rnd_a, 8'h02);
    tick();
    check("restart_2", rnd_a, 8'h04);

    // Rejection-sampling yield over 1000 clocks
    accepted = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (rnd_a < 6'd52) accepted++;
    end
    check_int("accept_count", accepted, 780, 870);

    // Random runs interrupted by random async resets of random length
    for (int k = 0; k < 40; k++) begin
      runlen = $urandom_range(1, 80);
      for (int i = 0; i < runlen; i++) tick();
      #($urandom_range(0, 1));
      do_reset($urandom_range(0, 2));
      tick();
      check("post_reset_a", rnd_a, 8'h02);
    end

    tick();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
